sipo_deserializer: RTL and testbench

Parametrised serial-in/parallel-out deserializer. It is the successor to the fixed 8-bit decoder, generalised in word width and bit order, with optional frame synchronisation. It adds a bit-strobe input, a valid/ready output handshake with a holding register, and a sticky overrun flag. It sits between the serial line receiver and the byte/word consumer in the EMDS datapath.

---
 rtl/sipo_deserializer.sv | 87 ++++++++
 tb/tb_sipo_deserializer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with configurable word width, bit order and frame hunting.
// The completed word is held in a valid/ready holding register; words that cannot be loaded set a sticky overrun flag.
module sipo_deserializer #(
    parameter int unsigned  WIDTH     = 8,
    parameter bit           LSB_FIRST = 1'b1,
    parameter bit           SYNC_MODE = 1'b0,
    localparam int unsigned CNT_W     = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             serialIn,
    input  logic             serialValid,
    input  logic             frameStart,
    input  logic             clearOverrun,
    output logic [WIDTH-1:0] parallelOut,
    output logic             outValid,
    input  logic             outReady,
    output logic             overrun,
    output logic [CNT_W-1:0] bitCount,
    output logic             synced
);

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_word;
    logic             last_bit;
    logic             can_load;

    // Shifted value doubles as the completed word on the last bit of a frame.
    always_comb begin
        shifted    = LSB_FIRST ? {serialIn, shreg[WIDTH-1:1]}
                               : {shreg[WIDTH-2:0], serialIn};
        first_word = LSB_FIRST ? {serialIn, {(WIDTH-1){1'b0}}}
                               : {{(WIDTH-1){1'b0}}, serialIn};
        last_bit   = (bitCount == CNT_W'(WIDTH - 1));
        can_load   = !outValid || outReady;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= SYNC_MODE ? HUNT : SHIFT;
            shreg       <= '0;
            parallelOut <= '0;
            outValid    <= 1'b0;
            overrun     <= 1'b0;
            bitCount    <= '0;
        end else begin
            if (outValid && outReady) begin
                outValid <= 1'b0;
            end
            // Clear first so a same-edge overrun below wins.
            if (clearOverrun) begin
                overrun <= 1'b0;
            end
            if (serialValid) begin
                if (frameStart) begin
                    shreg    <= first_word;
                    bitCount <= CNT_W'(1);
                    state    <= SHIFT;
                end else if (state == SHIFT) begin
                    if (last_bit) begin
                        shreg    <= '0;
                        bitCount <= '0;
                        if (can_load) begin
                            parallelOut <= shifted;
                            outValid    <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        shreg    <= shifted;
                        bitCount <= bitCount + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign synced = (state == SHIFT);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: four parameterisations share one stimulus bus.
`timescale 1ns/1ps
module tb_sipo_deserializer;

    logic clock, reset, serialIn, serialValid, frameStart, clearOverrun, outReady;

    // a: 8b LSB-first free-run, b: 8b MSB-first, c: 8b LSB-first hunting, d: 12b LSB-first
    logic [7:0]  po_a, po_b, po_c;
    logic [11:0] po_d;
    logic        ov_a, ov_b, ov_c, ov_d;
    logic        or_a, or_b, or_c, or_d;
    logic [2:0]  bc_a, bc_b, bc_c;
    logic [3:0]  bc_d;
    logic        sy_a, sy_b, sy_c, sy_d;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;

    sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1), .SYNC_MODE(1'b0)) u_a (
        .clock(clock), .reset(reset), .serialIn(serialIn), .serialValid(serialValid),
        .frameStart(frameStart), .clearOverrun(clearOverrun), .parallelOut(po_a),
        .outValid(ov_a), .outReady(outReady), .overrun(or_a), .bitCount(bc_a), .synced(sy_a));
    sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0), .SYNC_MODE(1'b0)) u_b (
        .clock(clock), .reset(reset), .serialIn(serialIn), .serialValid(serialValid),
        .frameStart(frameStart), .clearOverrun(clearOverrun), .parallelOut(po_b),
        .outValid(ov_b), .outReady(outReady), .overrun(or_b), .bitCount(bc_b), .synced(sy_b));
    sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1), .SYNC_MODE(1'b1)) u_c (
        .clock(clock), .reset(reset), .serialIn(serialIn), .serialValid(serialValid),
        .frameStart(frameStart), .clearOverrun(clearOverrun), .parallelOut(po_c),
        .outValid(ov_c), .outReady(outReady), .overrun(or_c), .bitCount(bc_c), .synced(sy_c));
    sipo_deserializer #(.WIDTH(12), .LSB_FIRST(1'b1), .SYNC_MODE(1'b0)) u_d (
        .clock(clock), .reset(reset), .serialIn(serialIn), .serialValid(serialValid),
        .frameStart(frameStart), .clearOverrun(clearOverrun), .parallelOut(po_d),
        .outValid(ov_d), .outReady(outReady), .overrun(or_d), .bitCount(bc_d), .synced(sy_d));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic b, input logic fs);
        serialValid = v;
        serialIn    = b;
        frameStart  = fs;
        step();
        serialValid = 1'b0;
        frameStart  = 1'b0;
        serialIn    = 1'b0;
    endtask

    // Sends n bits of w in transmission order (w[0] first); outReady/clearOverrun apply on the last bit.
    task automatic send_word(input logic [15:0] w, input int n, input logic rdy,
                             input logic rdy_last, input logic clr_last);
        logic [15:0] v;
        v = w;
        outReady = rdy;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
                outReady     = rdy_last;
                clearOverrun = clr_last;
            end
            drive(1'b1, v[i], 1'b0);
            clearOverrun = 1'b0;
        end
        outReady = rdy;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        serialValid  = 1'b0;
        serialIn     = 1'b0;
        frameStart   = 1'b0;
        clearOverrun = 1'b0;
        outReady     = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({po_a, ov_a, or_a, bc_a, sy_a} !== {8'h00, 1'b0, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_a got %h/%b/%b/%0d/%b want 00/0/0/0/1", po_a, ov_a, or_a, bc_a, sy_a);
        end
        checks++;
        if ({po_b, ov_b, or_b, bc_b, sy_b} !== {8'h00, 1'b0, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_b got %h/%b/%b/%0d/%b want 00/0/0/0/1", po_b, ov_b, or_b, bc_b, sy_b);
        end
        checks++;
        if ({po_c, ov_c, or_c, bc_c, sy_c} !== {8'h00, 1'b0, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hunt got %h/%b/%b/%0d/%b want 00/0/0/0/0", po_c, ov_c, or_c, bc_c, sy_c);
        end
    endtask

    task automatic test_lsb_basic();
        logic [7:0] pat;
        pat = 8'b1000_0101;
        do_reset();
        outReady = 1'b1;
        exp_q.push_back(16'h0085);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, pat[i], 1'b0);
            if (i == 2) begin
                checks++;
                if (bc_a !== 3'd3) begin
                    errors++;
                    $display("FAIL lsb_bitcount got %0d want 3", bc_a);
                end
            end
        end
        checks++;
        if (ov_a !== 1'b1) begin
            errors++;
            $display("FAIL lsb_valid got %b want 1", ov_a);
        end
        exp_w = exp_q.pop_front();
        checks++;
        if (po_a !== exp_w[7:0]) begin
            errors++;
            $display("FAIL lsb_word got %h want %h", po_a, exp_w[7:0]);
        end
        step();
        checks++;
        if (ov_a !== 1'b0) begin
            errors++;
            $display("FAIL lsb_consume got %b want 0", ov_a);
        end
    endtask

    task automatic test_msb_gaps();
        logic [7:0] pat;
        pat = 8'b1000_0101;
        do_reset();
        outReady = 1'b1;
        exp_q.push_back(16'h00A1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, pat[i], 1'b0);
            if (i < 7) begin
                drive(1'b0, 1'b1, 1'b1);
                checks++;
                if (bc_b !== 3'(i + 1)) begin
                    errors++;
                    $display("FAIL msb_gap_hold got %0d want %0d", bc_b, i + 1);
                end
            end
        end
        exp_w = exp_q.pop_front();
        checks++;
        if (ov_b !== 1'b1 || po_b !== exp_w[7:0] || bc_b !== 3'd0) begin
            errors++;
            $display("FAIL msb_word got %b/%h/%0d want 1/%h/0", ov_b, po_b, bc_b, exp_w[7:0]);
        end
    endtask

    task automatic test_hunt_resync();
        logic [7:0] w;
        do_reset();
        outReady = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (bc_c !== 3'd0 || sy_c !== 1'b0) begin
            errors++;
            $display("FAIL hunt_ignore got %0d/%b want 0/0", bc_c, sy_c);
        end
        w = 8'h3C;
        exp_q.push_back(16'h003C);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, w[i], i == 0);
            if (i == 0) begin
                checks++;
                if (sy_c !== 1'b1 || bc_c !== 3'd1) begin
                    errors++;
                    $display("FAIL hunt_lock got %b/%0d want 1/1", sy_c, bc_c);
                end
            end
        end
        exp_w = exp_q.pop_front();
        checks++;
        if (ov_c !== 1'b1 || po_c !== exp_w[7:0]) begin
            errors++;
            $display("FAIL hunt_word got %b/%h want 1/%h", ov_c, po_c, exp_w[7:0]);
        end
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        checks++;
        if (bc_c !== 3'd1 || sy_c !== 1'b1) begin
            errors++;
            $display("FAIL resync_count got %0d/%b want 1/1", bc_c, sy_c);
        end
        w = 8'h5A;
        exp_q.push_back(16'h005A);
        for (int i = 1; i < 8; i++) drive(1'b1, w[i], 1'b0);
        exp_w = exp_q.pop_front();
        checks++;
        if (ov_c !== 1'b1 || po_c !== exp_w[7:0]) begin
            errors++;
            $display("FAIL resync_word got %b/%h want 1/%h", ov_c, po_c, exp_w[7:0]);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        exp_q.push_back(16'h0011);
        send_word(16'h0011, 8, 1'b0, 1'b0, 1'b0);
        send_word(16'h0022, 8, 1'b0, 1'b0, 1'b0);
        exp_w = exp_q.pop_front();
        checks++;
        if (po_a !== exp_w[7:0] || ov_a !== 1'b1 || or_a !== 1'b1) begin
            errors++;
            $display("FAIL overrun_drop got %h/%b/%b want %h/1/1", po_a, ov_a, or_a, exp_w[7:0]);
        end
        clearOverrun = 1'b1;
        step();
        clearOverrun = 1'b0;
        checks++;
        if (or_a !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear got %b want 0", or_a);
        end
        send_word(16'h0033, 8, 1'b0, 1'b0, 1'b1);
        checks++;
        if (or_a !== 1'b1 || po_a !== 8'h11) begin
            errors++;
            $display("FAIL overrun_set_wins got %b/%h want 1/11", or_a, po_a);
        end
        outReady = 1'b1;
        step();
        checks++;
        if (ov_a !== 1'b0) begin
            errors++;
            $display("FAIL drain got %b want 0", ov_a);
        end
        exp_q.push_back(16'h0044);
        send_word(16'h0044, 8, 1'b0, 1'b0, 1'b0);
        exp_w = exp_q.pop_front();
        checks++;
        if (ov_a !== 1'b1 || po_a !== exp_w[7:0]) begin
            errors++;
            $display("FAIL framing_continue got %b/%h want 1/%h", ov_a, po_a, exp_w[7:0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        exp_q.push_back(16'h0011);
        send_word(16'h0011, 8, 1'b0, 1'b0, 1'b0);
        exp_w = exp_q.pop_front();
        checks++;
        if (po_a !== exp_w[7:0] || ov_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got %h/%b want %h/1", po_a, ov_a, exp_w[7:0]);
        end
        exp_q.push_back(16'h0022);
        send_word(16'h0022, 8, 1'b0, 1'b1, 1'b0);
        exp_w = exp_q.pop_front();
        checks++;
        if (po_a !== exp_w[7:0] || ov_a !== 1'b1 || or_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got %h/%b/%b want %h/1/0", po_a, ov_a, or_a, exp_w[7:0]);
        end
    endtask

    task automatic test_reset_midword_w12();
        do_reset();
        send_word(16'h05A5, 12, 1'b0, 1'b0, 1'b0);
        send_word(16'h00F0, 12, 1'b0, 1'b0, 1'b0);
        send_word(16'h001F, 5, 1'b0, 1'b0, 1'b0);
        checks++;
        if (po_d !== 12'h5A5 || or_d !== 1'b1 || bc_d !== 4'd5) begin
            errors++;
            $display("FAIL w12_pre got %h/%b/%0d want 5a5/1/5", po_d, or_d, bc_d);
        end
        reset = 1'b1;
        #2;
        checks++;
        if ({po_d, ov_d, or_d, bc_d} !== {12'h000, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL async_reset got %h/%b/%b/%0d want 000/0/0/0", po_d, ov_d, or_d, bc_d);
        end
        step();
        reset = 1'b0;
        exp_q.push_back(16'h0ABC);
        send_word(16'h0ABC, 12, 1'b1, 1'b1, 1'b0);
        exp_w = exp_q.pop_front();
        checks++;
        if (ov_d !== 1'b1 || po_d !== exp_w[11:0] || sy_d !== 1'b1) begin
            errors++;
            $display("FAIL w12_word got %b/%h/%b want 1/%h/1", ov_d, po_d, sy_d, exp_w[11:0]);
        end
    endtask

    initial begin
        test_reset();
        test_lsb_basic();
        test_msb_gaps();
        test_hunt_resync();
        test_backpressure();
        test_back_to_back();
        test_reset_midword_w12();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
